// File: rtl/ram_march_tester.sv
// March-style RAM tester: writes pat^addr to every word, reads back and compares,
// then repeats with the inverted pattern. Reports pass, first failing address and error count.
module ram_march_tester #(
  parameter int AW  = 2,
  parameter int DW  = 4,
  parameter int ECW = 4
) (
  input  logic           clk_2,
  input  logic           rst_n,
  input  logic           start,
  input  logic [DW-1:0]  pattern,
  output logic           mem_we,
  output logic [AW-1:0]  mem_addr,
  output logic [DW-1:0]  mem_wdata,
  input  logic [DW-1:0]  mem_rdata,
  output logic           busy,
  output logic           done,
  output logic           pass,
  output logic [AW-1:0]  fail_addr,
  output logic [ECW-1:0] err_count
);

  localparam logic [AW-1:0]  LAST_ADDR = {AW{1'b1}};
  localparam logic [ECW-1:0] ERR_MAX   = {ECW{1'b1}};
  localparam logic [ECW-1:0] ERR_ONE   = {{(ECW-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WR0       = 3'd1,
    S_RD0       = 3'd2,
    S_RD0_DRAIN = 3'd3,
    S_WR1       = 3'd4,
    S_RD1       = 3'd5,
    S_RD1_DRAIN = 3'd6,
    S_DONE      = 3'd7
  } state_e;

  function automatic logic [DW-1:0] exp_data(input logic [DW-1:0] pat,
                                             input logic [AW-1:0] a,
                                             input logic          inv);
    logic [DW-1:0] e;
    e = pat ^ DW'(a);
    return inv ? ~e : e;
  endfunction

  state_e         state_q, state_d;
  logic [AW-1:0]  addr_q, addr_d;
  logic [DW-1:0]  pat_q, pat_d;
  logic           cmp_vld_q, cmp_vld_d;
  logic [AW-1:0]  cmp_addr_q, cmp_addr_d;
  logic [DW-1:0]  cmp_exp_q, cmp_exp_d;
  logic [ECW-1:0] err_q, err_d;
  logic [AW-1:0]  fail_q, fail_d;
  logic           seen_q, seen_d;
  logic           phase1_s;
  logic           mismatch_s;
  logic [DW-1:0]  cur_exp_s;

  assign phase1_s  = (state_q == S_WR1) || (state_q == S_RD1) || (state_q == S_RD1_DRAIN);
  assign cur_exp_s = exp_data(pat_q, addr_q, phase1_s);
  // Compare pipe holds what was issued last cycle; RAM data arrives now.
  assign mismatch_s = cmp_vld_q && (mem_rdata != cmp_exp_q);

  // Next-state, address sequencing and error bookkeeping.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    pat_d      = pat_q;
    cmp_vld_d  = 1'b0;
    cmp_addr_d = addr_q;
    cmp_exp_d  = cur_exp_s;
    err_d      = err_q;
    fail_d     = fail_q;
    seen_d     = seen_q;

    if (mismatch_s) begin
      if (err_q != ERR_MAX) begin
        err_d = err_q + ERR_ONE;
      end else begin
        err_d = err_q;
      end
      if (!seen_q) begin
        fail_d = cmp_addr_q;
        seen_d = 1'b1;
      end else begin
        fail_d = fail_q;
      end
    end else begin
      err_d = err_q;
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          pat_d   = pattern;
          err_d   = {ECW{1'b0}};
          fail_d  = {AW{1'b0}};
          seen_d  = 1'b0;
          addr_d  = {AW{1'b0}};
          state_d = S_WR0;
        end else begin
          state_d = state_q;
        end
      end
      S_WR0, S_WR1: begin
        addr_d = addr_q + {{(AW-1){1'b0}}, 1'b1};
        if (addr_q == LAST_ADDR) begin
          state_d = (state_q == S_WR0) ? S_RD0 : S_RD1;
        end else begin
          state_d = state_q;
        end
      end
      S_RD0, S_RD1: begin
        cmp_vld_d = 1'b1;
        addr_d    = addr_q + {{(AW-1){1'b0}}, 1'b1};
        if (addr_q == LAST_ADDR) begin
          state_d = (state_q == S_RD0) ? S_RD0_DRAIN : S_RD1_DRAIN;
        end else begin
          state_d = state_q;
        end
      end
      S_RD0_DRAIN: state_d = S_WR1;
      S_RD1_DRAIN: state_d = S_DONE;
      default:     state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk_2) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      addr_q     <= {AW{1'b0}};
      pat_q      <= {DW{1'b0}};
      cmp_vld_q  <= 1'b0;
      cmp_addr_q <= {AW{1'b0}};
      cmp_exp_q  <= {DW{1'b0}};
      err_q      <= {ECW{1'b0}};
      fail_q     <= {AW{1'b0}};
      seen_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      pat_q      <= pat_d;
      cmp_vld_q  <= cmp_vld_d;
      cmp_addr_q <= cmp_addr_d;
      cmp_exp_q  <= cmp_exp_d;
      err_q      <= err_d;
      fail_q     <= fail_d;
      seen_q     <= seen_d;
    end
  end

  // Moore outputs decoded from state registers only.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = {AW{1'b0}};
    mem_wdata = {DW{1'b0}};
    case (state_q)
      S_WR0, S_WR1: begin
        mem_we    = 1'b1;
        mem_addr  = addr_q;
        mem_wdata = cur_exp_s;
      end
      S_RD0, S_RD1: mem_addr = addr_q;
      default:      mem_we = 1'b0;
    endcase
  end

  assign busy      = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done      = (state_q == S_DONE);
  assign pass      = (state_q == S_DONE) && (err_q == {ECW{1'b0}});
  assign fail_addr = fail_q;
  assign err_count = err_q;

endmodule

// File: doc/ram_march_tester.md
Name: ram_march_tester

Overview:
- Sequencer that acts as the initiator for the team's small synchronous r/w RAM (4 words × 4 bits, registered read).
- On `start` it writes an address-dependent pattern to every word, then reads each word back and compares.
- It then repeats the write/read pass with the inverted pattern and reports pass/fail, first failing address and error count.
- Sits beside the RAM in `top`: drives its address/data/write-enable and consumes its read data; results go to LEDs/LCD.

Parameters:
- AW, 2, address width; NWORDS = 2**AW (derived, not overridable).
- DW, 4, data width; DW >= AW required.
- ECW, 4, error-counter width; must hold 2*NWORDS (saturates at all-ones).

Ports:
- clk_2  in  1  system clock; all state changes on posedge.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  begin test; sampled only in IDLE and DONE.
- pattern  in  DW  base data pattern; sampled into a register when start is accepted.
- mem_we  out  1  RAM write enable (1 = write this cycle).
- mem_addr  out  AW  RAM address.
- mem_wdata  out  DW  RAM write data.
- mem_rdata  in  DW  RAM read data; valid the cycle after mem_addr is presented with mem_we=0.
- busy  out  1  test in progress.
- done  out  1  test finished; held until restart or reset.
- pass  out  1  done with zero mismatches.
- fail_addr  out  AW  address of the first mismatch of the run.
- err_count  out  ECW  number of mismatches, saturating.

Behaviour:
- All outputs are registered or decoded from state registers only (Moore); no combinational path from mem_rdata or start to outputs.
- Reset (rst_n=0 at a posedge):
  - state=IDLE, address counter=0, pattern reg=0.
  - mem_we=0, mem_addr=0, mem_wdata=0.
  - busy=0, done=0, pass=0, fail_addr=0, err_count=0.
  - Reset overrides everything, including mid-test; the RAM contents are not touched.
- Expected data: E0(a) = pat ^ zero-extended a; E1(a) = ~E0(a).
- States: IDLE, WR0, RD0, RD0_DRAIN, WR1, RD1, RD1_DRAIN, DONE.
- IDLE or DONE with start=1:
  - Capture pattern, clear err_count, fail_addr and the first-error flag, addr=0, go to WR0.
  - start=0 stays in the current state.
- WRx (one word per cycle):
  - mem_we=1, mem_addr=a, mem_wdata=Ex(a).
  - a increments each cycle; after a=NWORDS-1, wrap to a=0 and go to RDx.
- RDx:
  - mem_we=0, mem_addr=a, one address per cycle.
  - Each issue loads a compare pipe register (valid, a, Ex(a)).
  - After a=NWORDS-1, go to RDx_DRAIN.
- Compare: in the cycle after each issue (including the DRAIN cycle), mem_rdata != expected means
  - err_count += 1, saturating;
  - if this is the first error of the run, fail_addr is loaded with the compared address.
- RDx_DRAIN: performs the last compare only; mem_we=0. Next state is WR1 (from RD0) or DONE (from RD1).
- DONE:
  - done=1, busy=0, pass=(err_count==0).
  - mem_we=0; mem_addr and mem_wdata are driven 0.
  - Outputs hold until start or reset.
- busy=1 in every state except IDLE and DONE. start while busy is ignored.
- Timing: with start accepted at edge e0, WR0 occupies cycles 1..4, RD0 5..8, RD0_DRAIN 9, WR1 10..13, RD1 14..17, RD1_DRAIN 18, DONE from cycle 19. In general DONE is entered 4*NWORDS+2 cycles after start is accepted.
- Restart from DONE: done, pass and err_count clear in the first WR0 cycle.
- The compare pipe valid bit is cleared by reset and in IDLE, WRx and DONE, so no stale compare can occur.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles, including once mid-run → busy=0, done=0, pass=0, mem_we=0, mem_addr=0, err_count=0, fail_addr=0 on the cycle after the reset edge.
- Good RAM model, pattern=4'hA, 1-cycle start pulse →
  - WR0 writes A,B,8,9 to addresses 0..3;
  - WR1 writes 5,4,7,6;
  - done=1 at cycle 19, pass=1, err_count=0, busy high for cycles 1..18.
- Stuck-at fault, bit0 of word 2 stuck at 0, pattern=A → phase 0 passes (expected 8); phase 1 reads 6 against expected 7 → err_count=1, fail_addr=2, pass=0.
- Address alias, addr 3 decodes to word 1, pattern=A →
  - read of addr1 gives 9 (expected B);
  - phase 1 gives 6 (expected 4);
  - result: err_count=2, fail_addr=1, pass=0.
- Reset in RD0 cycle 6, then start with pattern=0 → state IDLE next cycle with mem_we=0; fresh run writes 0,1,2,3 then F,E,D,C; pass=1 at 19 cycles after start.
- start held high for the whole run → ignored while busy. start in DONE → WR0 next cycle, done=0, err_count=0.
